// File: rtl/dac_pacer_pkg.sv
// dac_pacer_pkg
// Shared definitions for the DAC sample pacer: the sample width of the
// rvmyth/avsddac path, the DAC mid-scale level used as the idle output,
// the default FIFO depth and a saturating increment for the underrun
// counter.
package dac_pacer_pkg;

  localparam int SAMPLE_W = 10;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 10'h200;
  localparam int DEFAULT_DEPTH = 8;

  localparam int UCNT_W = 8;
  localparam logic [UCNT_W-1:0] UCNT_MAX = 8'hFF;
  localparam logic [UCNT_W-1:0] UCNT_ONE = 8'h01;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
    if (v == UCNT_MAX) begin
      sat_inc = UCNT_MAX;
    end else begin
      sat_inc = v + UCNT_ONE;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with DEPTH-wrapping binary pointers carrying one extra
// MSB, so occupancy is a plain pointer difference and full/empty are never
// ambiguous. The head entry is presented combinationally on rdata.
// Ports:
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   push, wdata   : write wdata when push is high and the FIFO is not full
//   pop           : drop the head entry when pop is high and not empty
//   rdata         : current head entry (undefined content when empty)
//   fill          : occupancy, 0..DEPTH
//   full, empty   : occupancy decodes
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign fill      = wr_ptr_r - rd_ptr_r;
  assign full      = (fill == FULL_CNT);
  assign empty     = (fill == PTR_ZERO);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; reset discards the contents by equalising the pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage array; content needs no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer
// Rate-pacing buffer between the core's sample register and the DAC input
// bus. Samples arrive through valid/ready into a FIFO; one sample is
// released to the DAC per (div+1) clock cycles while enable is high. An
// empty FIFO at release time holds the last DAC value and is recorded as
// an underrun.
// Ports:
//   CLK, reset          : rising-edge clock, synchronous active-high reset
//   in_data, in_valid   : sample from the core; pushed when in_ready is high
//   in_ready            : FIFO not full (from registered state only)
//   enable, div         : pacing enable and period-minus-one in CLK cycles
//   clr_status          : clears underrun flag and counter
//   dac_d, dac_upd      : registered DAC sample and one-cycle update pulse
//   fill                : FIFO occupancy
//   underrun            : sticky underrun flag
//   underrun_cnt        : saturating underrun tick count
module dac_sample_pacer
  import dac_pacer_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DIV_W = 16
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       div,
  input  logic                   clr_status,
  output logic [WIDTH-1:0]       dac_d,
  output logic                   dac_upd,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   underrun,
  output logic [UCNT_W-1:0]      underrun_cnt
);

  // Idle DAC level; equals MIDSCALE at the native 10-bit width.
  localparam logic [WIDTH-1:0] MID_LVL   = WIDTH'(MIDSCALE);
  localparam logic [DIV_W-1:0] CNT_ZERO  = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [UCNT_W-1:0] UCNT_ZERO = {UCNT_W{1'b0}};

  logic [DIV_W-1:0] cnt_r;
  logic             tick_s;
  logic             push_s;
  logic             pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [WIDTH-1:0] head_s;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (in_data),
    .rdata (head_s),
    .fill  (fill),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Ready comes from the pointer registers, so a same-cycle pop never
  // reaches in_ready combinationally.
  assign in_ready = ~fifo_full_s;
  assign push_s   = in_valid & in_ready;
  assign pop_s    = tick_s & ~fifo_empty_s;

  // Tick decode; >= keeps a live decrease of div from running past the end.
  always_comb begin
    if (enable && (cnt_r >= div)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Pacing counter: held at zero while disabled, restarts after each tick.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
    end else if (!enable || tick_s) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // DAC output register; dac_d only moves on a pop so the async DAC load
  // sees a single clean transition per sample.
  always_ff @(posedge CLK) begin
    if (reset) begin
      dac_d   <= MID_LVL;
      dac_upd <= 1'b0;
    end else if (pop_s) begin
      dac_d   <= head_s;
      dac_upd <= 1'b1;
    end else begin
      dac_upd <= 1'b0;
    end
  end

  // Underrun status; an underrun tick wins over a simultaneous clear, so
  // the event that caused it is still counted.
  always_ff @(posedge CLK) begin
    if (reset) begin
      underrun     <= 1'b0;
      underrun_cnt <= UCNT_ZERO;
    end else if (tick_s && fifo_empty_s) begin
      underrun     <= 1'b1;
      underrun_cnt <= clr_status ? UCNT_ONE : sat_inc(underrun_cnt);
    end else if (clr_status) begin
      underrun     <= 1'b0;
      underrun_cnt <= UCNT_ZERO;
    end
  end

endmodule

// File: tb/tb_dac_sample_pacer.sv
// tb_dac_sample_pacer
// Self-checking bench for dac_sample_pacer: a hand-derived vector table for
// the pacing/underrun/simultaneous-push cases, hand-written sequences for
// reset, backpressure, mid-stream reset, saturation and live div changes,
// and a randomized run checked against a queue-based reference model.
module tb_dac_sample_pacer;

  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        reset;
  logic [9:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        enable;
  logic [15:0] div;
  logic        clr_status;
  logic [9:0]  dac_d;
  logic        dac_upd;
  logic [3:0]  fill;
  logic        underrun;
  logic [7:0]  underrun_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dac_sample_pacer #(.WIDTH(10), .DEPTH(DEPTH), .DIV_W(16)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .enable       (enable),
    .div          (div),
    .clr_status   (clr_status),
    .dac_d        (dac_d),
    .dac_upd      (dac_upd),
    .fill         (fill),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  // Reference model: sample queue, last DAC value and a count of cycles
  // enable has been continuously high (ticks fall where that count mod
  // (div+1) equals div).
  logic [9:0] m_q[$];
  logic [9:0] m_dac;
  bit         m_upd;
  bit         m_und;
  int         m_cnt;
  longint     m_run;
  bit         m_on = 1'b0;

  typedef struct {
    int         reps;
    logic       vld;
    logic [9:0] data;
    logic       clr;
    logic [9:0] e_dac;
    logic       e_upd;
    logic [3:0] e_fill;
    logic       e_und;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(int reps, logic vld, logic [9:0] data, logic clr,
                              logic [9:0] e_dac, logic e_upd, logic [3:0] e_fill,
                              logic e_und, logic [7:0] e_cnt);
    vec_t v;
    v.reps = reps; v.vld = vld; v.data = data; v.clr = clr;
    v.e_dac = e_dac; v.e_upd = e_upd; v.e_fill = e_fill;
    v.e_und = e_und; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit tick;
    bit push;
    bit was_empty;
    if (reset) begin
      m_q.delete();
      m_dac = 10'h200;
      m_upd = 1'b0;
      m_und = 1'b0;
      m_cnt = 0;
      m_run = 0;
      m_on  = 1'b1;
    end else begin
      push      = in_valid && (m_q.size() < DEPTH);
      tick      = enable && ((m_run % (longint'(div) + 1)) == longint'(div));
      was_empty = (m_q.size() == 0);
      m_upd     = 1'b0;
      if (tick && !was_empty) begin
        m_dac = m_q.pop_front();
        m_upd = 1'b1;
      end
      if (tick && was_empty) begin
        m_und = 1'b1;
        m_cnt = clr_status ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
      end else if (clr_status) begin
        m_und = 1'b0;
        m_cnt = 0;
      end
      if (push) m_q.push_back(in_data);
      m_run = enable ? m_run + 1 : 0;
    end
  endtask

  // One clock: model, edge, then compare all outputs 1 ns after the edge.
  task automatic cyc();
    model_step();
    @(posedge CLK);
    #1;
    if (m_on) begin
      check("mdl_dac_d", dac_d, m_dac);
      check("mdl_dac_upd", dac_upd, m_upd);
      check("mdl_fill", fill, m_q.size());
      check("mdl_in_ready", in_ready, (m_q.size() < DEPTH));
      check("mdl_underrun", underrun, m_und);
      check("mdl_underrun_cnt", underrun_cnt, m_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 10'h3FF;
    enable = 1'b0; div = 16'd3; clr_status = 1'b0;

    // Reset held two cycles with in_valid high.
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("rst_dac_d", dac_d, 10'h200);
      check("rst_fill", fill, 4'd0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_dac_upd", dac_upd, 1'b0);
      check("rst_underrun_cnt", underrun_cnt, 8'd0);
    end
    reset = 1'b0; in_valid = 1'b0;

    // Pacing with div=3, underrun, clear, simultaneous push/tick cases.
    tbl[0]  = mk(1, 1'b1, 10'h001, 1'b0, 10'h200, 1'b0, 4'd1, 1'b0, 8'd0);
    tbl[1]  = mk(1, 1'b1, 10'h002, 1'b0, 10'h200, 1'b0, 4'd2, 1'b0, 8'd0);
    tbl[2]  = mk(1, 1'b1, 10'h003, 1'b0, 10'h200, 1'b0, 4'd3, 1'b0, 8'd0);
    tbl[3]  = mk(1, 1'b0, 10'h000, 1'b0, 10'h001, 1'b1, 4'd2, 1'b0, 8'd0);
    tbl[4]  = mk(3, 1'b0, 10'h000, 1'b0, 10'h001, 1'b0, 4'd2, 1'b0, 8'd0);
    tbl[5]  = mk(1, 1'b0, 10'h000, 1'b0, 10'h002, 1'b1, 4'd1, 1'b0, 8'd0);
    tbl[6]  = mk(3, 1'b0, 10'h000, 1'b0, 10'h002, 1'b0, 4'd1, 1'b0, 8'd0);
    tbl[7]  = mk(1, 1'b0, 10'h000, 1'b0, 10'h003, 1'b1, 4'd0, 1'b0, 8'd0);
    tbl[8]  = mk(3, 1'b0, 10'h000, 1'b0, 10'h003, 1'b0, 4'd0, 1'b0, 8'd0);
    tbl[9]  = mk(1, 1'b0, 10'h000, 1'b0, 10'h003, 1'b0, 4'd0, 1'b1, 8'd1);
    tbl[10] = mk(3, 1'b0, 10'h000, 1'b0, 10'h003, 1'b0, 4'd0, 1'b1, 8'd1);
    tbl[11] = mk(1, 1'b0, 10'h000, 1'b0, 10'h003, 1'b0, 4'd0, 1'b1, 8'd2);
    tbl[12] = mk(3, 1'b0, 10'h000, 1'b0, 10'h003, 1'b0, 4'd0, 1'b1, 8'd2);
    tbl[13] = mk(1, 1'b0, 10'h000, 1'b0, 10'h003, 1'b0, 4'd0, 1'b1, 8'd3);
    tbl[14] = mk(1, 1'b0, 10'h000, 1'b1, 10'h003, 1'b0, 4'd0, 1'b0, 8'd0);
    tbl[15] = mk(2, 1'b0, 10'h000, 1'b0, 10'h003, 1'b0, 4'd0, 1'b0, 8'd0);
    tbl[16] = mk(1, 1'b1, 10'h0AB, 1'b0, 10'h003, 1'b0, 4'd1, 1'b1, 8'd1);
    tbl[17] = mk(3, 1'b0, 10'h000, 1'b0, 10'h003, 1'b0, 4'd1, 1'b1, 8'd1);
    tbl[18] = mk(1, 1'b1, 10'h0CD, 1'b0, 10'h0AB, 1'b1, 4'd1, 1'b1, 8'd1);
    tbl[19] = mk(3, 1'b0, 10'h000, 1'b0, 10'h0AB, 1'b0, 4'd1, 1'b1, 8'd1);
    tbl[20] = mk(1, 1'b0, 10'h000, 1'b0, 10'h0CD, 1'b1, 4'd0, 1'b1, 8'd1);
    tbl[21] = mk(3, 1'b0, 10'h000, 1'b0, 10'h0CD, 1'b0, 4'd0, 1'b1, 8'd1);
    tbl[22] = mk(1, 1'b0, 10'h000, 1'b0, 10'h0CD, 1'b0, 4'd0, 1'b1, 8'd2);
    tbl[23] = mk(3, 1'b0, 10'h000, 1'b0, 10'h0CD, 1'b0, 4'd0, 1'b1, 8'd2);
    tbl[24] = mk(1, 1'b0, 10'h000, 1'b1, 10'h0CD, 1'b0, 4'd0, 1'b1, 8'd1);

    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        in_valid = tbl[r].vld; in_data = tbl[r].data;
        clr_status = tbl[r].clr; enable = 1'b1; div = 16'd3;
        cyc();
        check($sformatf("tbl%0d_dac_d", r), dac_d, tbl[r].e_dac);
        check($sformatf("tbl%0d_dac_upd", r), dac_upd, tbl[r].e_upd);
        check($sformatf("tbl%0d_fill", r), fill, tbl[r].e_fill);
        check($sformatf("tbl%0d_underrun", r), underrun, tbl[r].e_und);
        check($sformatf("tbl%0d_underrun_cnt", r), underrun_cnt, tbl[r].e_cnt);
      end
    end
    in_valid = 1'b0; clr_status = 1'b0;

    // Backpressure: fill while disabled, then drain at div=0.
    reset = 1'b1; enable = 1'b0; cyc(); reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = 10'(10'h100 + i);
      cyc();
      if (i == 7) check("bp_ready_drop", in_ready, 1'b0);
    end
    check("bp_fill_full", fill, 4'd8);
    check("bp_ready_full", in_ready, 1'b0);
    enable = 1'b1; div = 16'd0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      check("bp_dac_upd", dac_upd, 1'b1);
      check("bp_dac_d", dac_d, 10'(10'h100 + i));
      if (i == 0) check("bp_ready_back", in_ready, 1'b1);
      if (i == 1) in_valid = 1'b0;
    end

    // Mid-stream reset: build up underruns and 5 entries, then reset.
    for (int i = 0; i < 3; i++) cyc();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 10'(10'h050 + i);
      cyc();
    end
    in_valid = 1'b0;
    check("mid_fill_pre", fill, 4'd5);
    check("mid_ucnt_pre", underrun_cnt, 8'd3);
    reset = 1'b1; cyc(); reset = 1'b0;
    check("mid_fill", fill, 4'd0);
    check("mid_dac_d", dac_d, 10'h200);
    check("mid_ucnt", underrun_cnt, 8'd0);
    check("mid_upd", dac_upd, 1'b0);

    // Underrun counter saturation.
    enable = 1'b1; div = 16'd0;
    for (int i = 0; i < 260; i++) cyc();
    check("sat_ucnt", underrun_cnt, 8'd255);
    check("sat_und", underrun, 1'b1);

    // Live decrease of div below the running count ticks immediately.
    reset = 1'b1; enable = 1'b0; cyc(); reset = 1'b0;
    m_on = 1'b0;
    enable = 1'b1; div = 16'd7; in_valid = 1'b1; in_data = 10'h2AA;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("live_noupd", dac_upd, 1'b0);
    end
    div = 16'd2;
    cyc();
    check("live_upd", dac_upd, 1'b1);
    check("live_dac_d", dac_d, 10'h2AA);
    cyc(); cyc();
    check("live_und_wait", underrun, 1'b0);
    cyc();
    check("live_und", underrun, 1'b1);
    check("live_ucnt", underrun_cnt, 8'd1);

    // Randomized traffic against the model.
    reset = 1'b1; enable = 1'b0; cyc(); reset = 1'b0; div = 16'd2;
    for (int c = 0; c < 3000; c++) begin
      if (enable) begin
        if ($urandom_range(0, 39) == 0) begin
          enable = 1'b0;
          div = 16'($urandom_range(0, 5));
        end
      end else if ($urandom_range(0, 2) == 0) begin
        enable = 1'b1;
      end
      in_valid   = ($urandom_range(0, 99) < 40);
      in_data    = 10'($urandom);
      clr_status = ($urandom_range(0, 29) == 0);
      reset      = ($urandom_range(0, 499) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
